dmem_arbiter: RTL and testbench

Shares the single data memory and peripheral port between the pipeline's MEM stage and a DMA requester (boot loader or UART bridge). Arbitration is combinational and done in the same cycle as the request. Registered round-robin, lock and burst state keep the sharing fair. When the CPU loses arbitration, `cpu_stall` freezes the PC and all pipeline registers for that cycle, and the MEM-stage access is retried on the next cycle.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/rr_lock_arb.sv | 71 +++++++
 rtl/dmem_arbiter.sv | 87 ++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: owner encoding and the default
// lock/burst length.
package dmem_pkg;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   localparam int DEF_MAX_BURST = 8;

   // Round-robin choice when neither lock nor burst limit decides the contention
   function automatic logic rr_pick(input logic last_dma);
      return last_dma ? OWN_CPU : OWN_DMA;
   endfunction

endpackage

// File: rtl/rr_lock_arb.sv
// Two-requester arbiter: round-robin with a DMA lock that is bounded by MAX_BURST
// consecutive grants. Grants are combinational from requests and registered state.
module rr_lock_arb
   import dmem_pkg::*;
#(
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic dma_lock,
   output logic cpu_gnt,
   output logic dma_gnt
);

   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

   logic               last_dma_reg, last_dma_next;
   logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;
   logic               lock_hold;
   logic               burst_full;

   assign burst_full = (burst_cnt_reg == BURST_LIMIT);
   assign lock_hold  = dma_lock & last_dma_reg & (burst_cnt_reg < BURST_LIMIT);

   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!reset) begin
         if (cpu_req && dma_req) begin
            // The burst limit overrides the lock so the CPU wait stays bounded
            if (burst_full) begin
               cpu_gnt = 1'b1;
            end else if (lock_hold) begin
               dma_gnt = 1'b1;
            end else if (rr_pick(last_dma_reg) == OWN_DMA) begin
               dma_gnt = 1'b1;
            end else begin
               cpu_gnt = 1'b1;
            end
         end else begin
            cpu_gnt = cpu_req;
            dma_gnt = dma_req;
         end
      end
   end

   always_comb begin
      last_dma_next  = last_dma_reg;
      burst_cnt_next = '0;
      if (dma_gnt) begin
         last_dma_next  = 1'b1;
         burst_cnt_next = burst_full ? burst_cnt_reg : burst_cnt_reg + BURST_W'(1);
      end else if (cpu_gnt) begin
         last_dma_next  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_dma_reg  <= 1'b1;
         burst_cnt_reg <= '0;
      end else begin
         last_dma_reg  <= last_dma_next;
         burst_cnt_reg <= burst_cnt_next;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory port between the CPU MEM stage and a DMA requester;
// muxes address/data, generates strobes and counts CPU stall cycles.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_wr,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_stall,
   input  logic             dma_req,
   input  logic             dma_wr,
   input  logic [31:0]      dma_addr,
   input  logic [31:0]      dma_wdata,
   input  logic             dma_lock,
   output logic [31:0]      dma_rdata,
   output logic             dma_ack,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             cpu_gnt, dma_gnt, any_gnt, owner;
   logic [31:0]      port_addr  [2];
   logic [31:0]      port_wdata [2];
   logic             port_wr    [2];
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

   rr_lock_arb #(
      .MAX_BURST(MAX_BURST)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .cpu_req (cpu_req),
      .dma_req (dma_req),
      .dma_lock(dma_lock),
      .cpu_gnt (cpu_gnt),
      .dma_gnt (dma_gnt)
   );

   assign port_addr[OWN_CPU]  = cpu_addr;
   assign port_addr[OWN_DMA]  = dma_addr;
   assign port_wdata[OWN_CPU] = cpu_wdata;
   assign port_wdata[OWN_DMA] = dma_wdata;
   assign port_wr[OWN_CPU]    = cpu_wr;
   assign port_wr[OWN_DMA]    = dma_wr;

   // With no grant the CPU side drives the bus, so the memory sees a stable address
   assign owner     = dma_gnt ? OWN_DMA : OWN_CPU;
   assign any_gnt   = cpu_gnt | dma_gnt;
   assign mem_addr  = port_addr[owner];
   assign mem_wdata = port_wdata[owner];
   assign mem_rd    = any_gnt & ~port_wr[owner];
   assign mem_wr    = any_gnt &  port_wr[owner];

   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;
   assign dma_ack   = dma_gnt;
   assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (cpu_stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_next = stall_cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected per-cycle results are queued when
// stimulus is driven and compared on the following falling edge.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        cpu_req, cpu_wr, dma_req, dma_wr, dma_lock;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_stall, dma_ack, mem_rd, mem_wr;
   logic [15:0] stall_cnt;

   logic [31:0] cpu_rdata4, dma_rdata4, mem_addr4, mem_wdata4;
   logic        cpu_stall4, dma_ack4, mem_rd4, mem_wr4;
   logic [3:0]  stall_cnt4;

   dmem_arbiter #(.MAX_BURST(8), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_lock(dma_lock), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
   );

   dmem_arbiter #(.MAX_BURST(8), .CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata4), .cpu_stall(cpu_stall4),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_lock(dma_lock), .dma_rdata(dma_rdata4), .dma_ack(dma_ack4),
      .mem_rd(mem_rd4), .mem_wr(mem_wr4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
      .mem_rdata(32'h0), .stall_cnt(stall_cnt4)
   );

   // Small word-addressed memory, combinational read, write at the edge
   logic [31:0] mem [0:63];
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
   end

   typedef struct {
      string       tag;
      logic        ack;
      logic        stall;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      int          rsel;   // 0 none, 1 cpu_rdata, 2 dma_rdata
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Monitor: pop one expectation per cycle on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("%0t %s ack=%b stall=%b rd=%b wr=%b addr=%h", $time, e.tag,
                     dma_ack, cpu_stall, mem_rd, mem_wr, mem_addr);
            chk({e.tag, ".ack"},   {31'd0, dma_ack},   {31'd0, e.ack});
            chk({e.tag, ".stall"}, {31'd0, cpu_stall}, {31'd0, e.stall});
            chk({e.tag, ".rd"},    {31'd0, mem_rd},    {31'd0, e.rd});
            chk({e.tag, ".wr"},    {31'd0, mem_wr},    {31'd0, e.wr});
            chk({e.tag, ".addr"},  mem_addr,           e.addr);
            if (e.rsel == 1) chk({e.tag, ".cpu_rdata"}, cpu_rdata, e.rdata);
            if (e.rsel == 2) chk({e.tag, ".dma_rdata"}, dma_rdata, e.rdata);
         end
      end
   end

   task automatic drive(input logic rst, input logic cr, input logic cw, input logic [31:0] ca,
                        input logic [31:0] cd, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd, input logic dl);
      reset = rst; cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_wr = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
   endtask

   task automatic step(input string tag, input logic ack, input logic stall, input logic rd,
                       input logic wr, input logic [31:0] addr, input int rsel,
                       input logic [31:0] rdata);
      exp_t e;
      e.tag = tag; e.ack = ack; e.stall = stall; e.rd = rd; e.wr = wr;
      e.addr = addr; e.rsel = rsel; e.rdata = rdata;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] CA = 32'h40;
   localparam logic [31:0] DA = 32'h80;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      drive(1, 1, 0, CA, 0, 1, 0, DA, 0, 1);
      @(posedge clk);
      #1;

      // Reset held two cycles with both requests high
      step("rst0", 0, 0, 0, 0, CA, 0, 0);
      step("rst1", 0, 0, 0, 0, CA, 0, 0);
      chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);

      // Contention without lock from reset: CPU, DMA, CPU, DMA
      drive(0, 1, 0, CA, 0, 1, 0, DA, 0, 0);
      step("rr0", 0, 0, 1, 0, CA, 0, 0);
      step("rr1", 1, 1, 1, 0, DA, 0, 0);
      step("rr2", 0, 0, 1, 0, CA, 0, 0);
      step("rr3", 1, 1, 1, 0, DA, 0, 0);
      drive(0, 0, 0, CA, 0, 0, 0, DA, 0, 0);
      step("idle0", 0, 0, 0, 0, CA, 0, 0);
      chk("rr.stall_cnt", {16'd0, stall_cnt}, 32'd2);

      // CPU-only write then read back
      drive(0, 1, 1, 32'h10, 32'h1234_5678, 0, 0, DA, 0, 0);
      step("cpu_wr", 0, 0, 0, 1, 32'h10, 0, 0);
      drive(0, 1, 0, 32'h10, 0, 0, 0, DA, 0, 0);
      step("cpu_rd", 0, 0, 1, 0, 32'h10, 1, 32'h1234_5678);

      // DMA-only write, read by CPU; DMA-only read of the CPU's word
      drive(0, 0, 0, CA, 0, 1, 1, 32'h20, 32'hCAFE_F00D, 0);
      step("dma_wr", 1, 0, 0, 1, 32'h20, 0, 0);
      drive(0, 1, 0, 32'h20, 0, 0, 0, DA, 0, 0);
      step("cpu_rd2", 0, 0, 1, 0, 32'h20, 1, 32'hCAFE_F00D);
      drive(0, 0, 0, CA, 0, 1, 0, 32'h10, 0, 0);
      step("dma_rd", 1, 0, 1, 0, 32'h10, 2, 32'h1234_5678);
      drive(0, 0, 0, CA, 0, 0, 0, DA, 0, 0);
      step("idle1", 0, 0, 0, 0, CA, 0, 0);

      // Locked burst: DMA last owner, 8 DMA grants then CPU on the 9th
      drive(0, 1, 0, CA, 0, 1, 0, DA, 0, 1);
      for (int i = 0; i < 8; i++) step($sformatf("lock%0d", i), 1, 1, 1, 0, DA, 0, 0);
      step("lock8", 0, 0, 1, 0, CA, 0, 0);
      drive(0, 0, 0, CA, 0, 0, 0, DA, 0, 0);
      step("idle2", 0, 0, 0, 0, CA, 0, 0);
      chk("lock.stall_cnt", {16'd0, stall_cnt}, 32'd10);

      // Lock dropped at burst count 3
      drive(0, 0, 0, CA, 0, 1, 0, DA, 0, 1);
      step("drop_d", 1, 0, 1, 0, DA, 0, 0);
      drive(0, 1, 0, CA, 0, 1, 0, DA, 0, 1);
      step("drop_l0", 1, 1, 1, 0, DA, 0, 0);
      step("drop_l1", 1, 1, 1, 0, DA, 0, 0);
      chk("drop.burst3", {28'd0, u_dut.u_arb.burst_cnt_reg}, 32'd3);
      drive(0, 1, 0, CA, 0, 1, 0, DA, 0, 0);
      step("drop_cpu", 0, 0, 1, 0, CA, 0, 0);
      chk("drop.burst0", {28'd0, u_dut.u_arb.burst_cnt_reg}, 32'd0);
      drive(0, 0, 0, CA, 0, 0, 0, DA, 0, 0);
      step("idle3", 0, 0, 0, 0, CA, 0, 0);
      chk("drop.stall_cnt", {16'd0, stall_cnt}, 32'd12);

      // Reset at burst count 5: CPU wins the first contention afterwards
      drive(0, 0, 0, CA, 0, 1, 0, DA, 0, 1);
      step("mid_d", 1, 0, 1, 0, DA, 0, 0);
      drive(0, 1, 0, CA, 0, 1, 0, DA, 0, 1);
      for (int i = 0; i < 4; i++) step($sformatf("mid_l%0d", i), 1, 1, 1, 0, DA, 0, 0);
      chk("mid.burst5", {28'd0, u_dut.u_arb.burst_cnt_reg}, 32'd5);
      drive(1, 1, 0, CA, 0, 1, 0, DA, 0, 1);
      step("mid_rst", 0, 0, 0, 0, CA, 0, 0);
      drive(0, 1, 0, CA, 0, 1, 0, DA, 0, 0);
      step("mid_cpu", 0, 0, 1, 0, CA, 0, 0);
      chk("mid.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      step("mid_dma", 1, 1, 1, 0, DA, 0, 0);

      // Saturation: 20 stall cycles, 4-bit counter sticks at 15
      drive(1, 1, 0, CA, 0, 1, 0, DA, 0, 0);
      step("sat_rst", 0, 0, 0, 0, CA, 0, 0);
      drive(0, 1, 0, CA, 0, 1, 0, DA, 0, 0);
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) step($sformatf("sat%0d", i), 0, 0, 1, 0, CA, 0, 0);
         else            step($sformatf("sat%0d", i), 1, 1, 1, 0, DA, 0, 0);
      end
      drive(0, 0, 0, CA, 0, 0, 0, DA, 0, 0);
      step("idle4", 0, 0, 0, 0, CA, 0, 0);
      chk("sat.stall_cnt16", {16'd0, stall_cnt}, 32'd20);
      chk("sat.stall_cnt4", {28'd0, stall_cnt4}, 32'd15);
      chk("sb.empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
